gpio_bank: RTL and testbench

- Parametrised, register-mapped GPIO port that replaces the single fixed `gpio_out` line.
- `WIDTH` pins, each with:
  - per-pin direction and output data;
  - synchronised inputs;
  - edge-detect interrupts.
- Sits between the processor's peripheral bus and the top-level bidirectional pins.
- Drives the pin-level output and output-enable vectors directly.

---
 rtl/gpio_bank_pkg.sv | 18 +
 rtl/gpio_in_cond.sv | 80 ++++++++
 rtl/gpio_bank.sv | 139 +++++++++++++
 tb/tb_gpio_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map and edge-select encodings shared by the GPIO bank.
package gpio_bank_pkg;

  // Register indices on the 3-bit peripheral address
  localparam logic [2:0] GPIO_ADDR_OUT   = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DIR   = 3'd1;
  localparam logic [2:0] GPIO_ADDR_IN    = 3'd2;
  localparam logic [2:0] GPIO_ADDR_IEN   = 3'd3;
  localparam logic [2:0] GPIO_ADDR_ISTAT = 3'd4;
  localparam logic [2:0] GPIO_ADDR_EDGE  = 3'd5;
  localparam logic [2:0] GPIO_ADDR_SET   = 3'd6;
  localparam logic [2:0] GPIO_ADDR_CLR   = 3'd7;

  // Per-pin edge select held in the EDGE register
  localparam logic GPIO_EDGE_RISE = 1'b0;
  localparam logic GPIO_EDGE_FALL = 1'b1;

endpackage

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: conditions one asynchronous pad input.
// Synchroniser chain, optional debounce filter (GPIO_DEBOUNCE_EN), and a
// history flop producing single-cycle rise/fall pulses on the filtered level.
module gpio_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic                   prev_q, prev_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the pad value into the synchroniser; prev tracks the filtered level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = level;
  end

  // Synchroniser and edge-history registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_s != filt_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        filt_d = sync_s;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Debounce counter and filtered level registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q  <= {CNT_W{1'b0}};
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_s;
`endif

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: register-mapped GPIO port with per-pin direction, output data,
// synchronised inputs and sticky edge interrupts.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] level_s, rise_s, fall_s, hit_s, w1c_s, rd_mux_s;

  // One input conditioner per pin
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_in_cond (
      .CLK    (CLK),
      .reset  (reset),
      .pin_in (pin_in[i]),
      .level  (level_s[i]),
      .rise   (rise_s[i]),
      .fall   (fall_s[i])
    );
  end

  // Select the edge polarity each pin listens for
  always_comb begin
    hit_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      hit_s[i] = (edge_sel_q[i] == GPIO_EDGE_FALL) ? fall_s[i] : rise_s[i];
    end
  end

  // Read mux over current register contents (pre-write on a same-cycle write)
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    case (addr)
      GPIO_ADDR_OUT:   rd_mux_s = out_q;
      GPIO_ADDR_DIR:   rd_mux_s = dir_q;
      GPIO_ADDR_IN:    rd_mux_s = level_s;
      GPIO_ADDR_IEN:   rd_mux_s = ien_q;
      GPIO_ADDR_ISTAT: rd_mux_s = istat_q;
      GPIO_ADDR_EDGE:  rd_mux_s = edge_sel_q;
      GPIO_ADDR_SET:   rd_mux_s = {WIDTH{1'b0}};
      GPIO_ADDR_CLR:   rd_mux_s = {WIDTH{1'b0}};
      default:         rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Register write decode, sticky status update, read capture and irq
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ien_d      = ien_q;
    edge_sel_d = edge_sel_q;
    w1c_s      = {WIDTH{1'b0}};
    if (wr_en) begin
      case (addr)
        GPIO_ADDR_OUT:   out_d      = wdata;
        GPIO_ADDR_DIR:   dir_d      = wdata;
        GPIO_ADDR_IN:    out_d      = out_q;
        GPIO_ADDR_IEN:   ien_d      = wdata;
        GPIO_ADDR_ISTAT: w1c_s      = wdata;
        GPIO_ADDR_EDGE:  edge_sel_d = wdata;
        GPIO_ADDR_SET:   out_d      = out_q | wdata;
        GPIO_ADDR_CLR:   out_d      = out_q & ~wdata;
        default:         out_d      = out_q;
      endcase
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end

    // A fresh edge beats a simultaneous write-one-to-clear
    istat_d = (istat_q & ~w1c_s) | hit_s;

    if (rd_en) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
    rvalid_d = rd_en;
    irq_d    = |(istat_q & ien_q);
  end

  // Bank state registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_q      <= {WIDTH{1'b0}};
      dir_q      <= {WIDTH{1'b0}};
      ien_q      <= {WIDTH{1'b0}};
      istat_q    <= {WIDTH{1'b0}};
      edge_sel_q <= {WIDTH{1'b0}};
      rdata_q    <= {WIDTH{1'b0}};
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ien_q      <= ien_d;
      istat_q    <= istat_d;
      edge_sel_q <= edge_sel_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of the GPIO bank (WIDTH = 8, SYNC_STAGES = 2).
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC;
`endif

  logic       CLK;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       irq;

  int vectors;
  int miscompares;

  gpio_bank #(
    .WIDTH       (8),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
    wdata = 8'h00;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    chk({tag, ".rvalid"}, {31'd0, rvalid}, 32'd1);
    chk(tag, {24'd0, rdata}, {24'd0, exp});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    addr   = 3'd0;
    wdata  = 8'h00;
    pin_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst.pin_out", {24'd0, pin_out}, 32'h00);
    chk("rst.pin_oe",  {24'd0, pin_oe},  32'h00);
    chk("rst.irq",     {31'd0, irq},     32'd0);
    chk("rst.rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst.rdata",   {24'd0, rdata},   32'h00);

    // Read every address: zero data, rvalid for exactly one cycle
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 8'h00, $sformatf("rst.rd%0d", a));
      tick();
      chk($sformatf("rst.rd%0d.rvalid_low", a), {31'd0, rvalid}, 32'd0);
    end

    // Direction and output data
    wr(GPIO_ADDR_DIR, 8'hF0);
    wr(GPIO_ADDR_OUT, 8'hA5);
    chk("pin_oe",  {24'd0, pin_oe},  32'hF0);
    chk("pin_out", {24'd0, pin_out}, 32'hA5);
    rd(GPIO_ADDR_OUT, 8'hA5, "rd.out");
    tick();
    chk("rdata.hold",       {24'd0, rdata},  32'hA5);
    chk("rdata.hold.valid", {31'd0, rvalid}, 32'd0);
    rd(GPIO_ADDR_DIR, 8'hF0, "rd.dir");
    wr(GPIO_ADDR_SET, 8'h02);
    rd(GPIO_ADDR_OUT, 8'hA7, "set.out");
    rd(GPIO_ADDR_SET, 8'h00, "rd.set_wo");
    wr(GPIO_ADDR_CLR, 8'h81);
    rd(GPIO_ADDR_OUT, 8'h26, "clr.out");
    rd(GPIO_ADDR_CLR, 8'h00, "rd.clr_wo");
    chk("clr.pin_out", {24'd0, pin_out}, 32'h26);
    wr(GPIO_ADDR_IN, 8'hFF);
    rd(GPIO_ADDR_IN, 8'h00, "in.write_ignored");

    // Input synchronisation latency
    pin_in = 8'h3C;
    tick();
    rd(GPIO_ADDR_IN, 8'h00, "sync.early");
    repeat (LAT - 2) tick();
    rd(GPIO_ADDR_IN, 8'h3C, "sync.late");
    rd(GPIO_ADDR_ISTAT, 8'h3C, "istat.no_ien");
    chk("istat.no_ien.irq", {31'd0, irq}, 32'd0);
    wr(GPIO_ADDR_ISTAT, 8'hFF);
    rd(GPIO_ADDR_ISTAT, 8'h00, "istat.w1c_all");

    // Rising-edge interrupt on pin 0
    wr(GPIO_ADDR_IEN, 8'h01);
    wr(GPIO_ADDR_EDGE, 8'h00);
    pin_in = 8'h3D;
    repeat (LAT + 2) tick();
    chk("rise.irq", {31'd0, irq}, 32'd1);
    rd(GPIO_ADDR_ISTAT, 8'h01, "rise.istat");
    wr(GPIO_ADDR_ISTAT, 8'h01);
    tick();
    chk("w1c.irq_low", {31'd0, irq}, 32'd0);
    pin_in = 8'h3C;
    repeat (LAT + 2) tick();
    rd(GPIO_ADDR_ISTAT, 8'h00, "fall.no_event");
    chk("fall.no_irq", {31'd0, irq}, 32'd0);

    // Falling-edge select; changing EDGE alone raises nothing
    wr(GPIO_ADDR_EDGE, 8'h01);
    rd(GPIO_ADDR_ISTAT, 8'h00, "edge_change.no_event");
    pin_in = 8'h3D;
    repeat (LAT + 2) tick();
    rd(GPIO_ADDR_ISTAT, 8'h00, "fallsel.rise_ignored");
    pin_in = 8'h3C;
    repeat (LAT + 2) tick();
    rd(GPIO_ADDR_ISTAT, 8'h01, "fallsel.fall");
    chk("fallsel.irq", {31'd0, irq}, 32'd1);
    wr(GPIO_ADDR_ISTAT, 8'h01);
    wr(GPIO_ADDR_EDGE, 8'h00);
    tick();
    rd(GPIO_ADDR_ISTAT, 8'h00, "fallsel.cleared");

    // Set-over-clear collision
    pin_in = 8'h3D;
    repeat (LAT + 2) tick();
    rd(GPIO_ADDR_ISTAT, 8'h01, "coll.pre");
    pin_in = 8'h3C;
    repeat (LAT + 2) tick();
    pin_in = 8'h3D;
    repeat (LAT) tick();
    wr(GPIO_ADDR_ISTAT, 8'h01);
    tick();
    chk("coll.irq", {31'd0, irq}, 32'd1);
    rd(GPIO_ADDR_ISTAT, 8'h01, "coll.istat");

    // Same-cycle read and write returns pre-write value
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = GPIO_ADDR_OUT;
    wdata = 8'h55;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("rdwr.rvalid",  {31'd0, rvalid}, 32'd1);
    chk("rdwr.rdata",   {24'd0, rdata},  32'h26);
    chk("rdwr.pin_out", {24'd0, pin_out}, 32'h55);
    rd(GPIO_ADDR_OUT, 8'h55, "rdwr.after");

    // Mid-operation reset
    reset = 1'b1;
    tick();
    chk("mid_rst.pin_out", {24'd0, pin_out}, 32'h00);
    chk("mid_rst.pin_oe",  {24'd0, pin_oe},  32'h00);
    chk("mid_rst.irq",     {31'd0, irq},     32'd0);
    chk("mid_rst.rvalid",  {31'd0, rvalid},  32'd0);
    chk("mid_rst.rdata",   {24'd0, rdata},   32'h00);
    reset = 1'b0;
    rd(GPIO_ADDR_ISTAT, 8'h00, "mid_rst.istat");
    rd(GPIO_ADDR_IN, 8'h00, "mid_rst.in");

    // Short pulse then sustained high on pin 1
    repeat (LAT + 5) tick();
    wr(GPIO_ADDR_ISTAT, 8'hFF);
    rd(GPIO_ADDR_ISTAT, 8'h00, "pulse.pre");
    pin_in = 8'h3F;
    repeat (10) tick();
    pin_in = 8'h3D;
    repeat (LAT + 5) tick();
    rd(GPIO_ADDR_IN, 8'h3D, "pulse.in");
`ifdef GPIO_DEBOUNCE_EN
    rd(GPIO_ADDR_ISTAT, 8'h00, "pulse.istat");
`else
    rd(GPIO_ADDR_ISTAT, 8'h02, "pulse.istat");
`endif
    pin_in = 8'h3F;
    repeat (LAT + 4) tick();
    rd(GPIO_ADDR_IN, 8'h3F, "hold.in");
    rd(GPIO_ADDR_ISTAT, 8'h02, "hold.istat");
    pin_in = 8'h3D;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
